frame_loader: RTL

Upstream stage of the sync-frame checker: takes the received byte stream, hunts for the start byte, writes one complete frame into the 256-byte receive RAM (address 0 upward), then pulses `start` to the downstream checker. The checker validates start byte, address, and checksum, then copies the frame. After `start`, this block refuses new bytes for a guard window so the checker's read pass over the RAM is never corrupted.

---
 rtl/frame_loader_pkg.sv | 24 ++
 rtl/frame_loader_if.sv | 26 ++
 rtl/frame_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frame_loader_pkg.sv
// Sync-frame constants shared by the frame loader and the downstream checker.
package frame_loader_pkg;

  localparam logic [7:0]  START_BYTE = 8'hAA;
  localparam int          FRAME_LEN  = 256;
  localparam logic [7:0]  SYNC_ADR   = 8'h01;
  localparam int          CSUM_POS   = FRAME_LEN - 2;
  localparam logic [15:0] TIMEOUT    = 16'd5000;
  localparam logic [15:0] GUARD      = 16'd300;
  localparam int          IDX_W      = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DONE = ST_DONE,
    HOLD = ST_HOLD
  } state_t;

endpackage

// File: rtl/frame_loader_if.sv
// Byte-stream input and receive-RAM write / status output of the frame loader.
interface frame_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] ram_adr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       start;
  logic       busy;
  logic       err_timeout;
  logic       err_drop;

  // Loader side: consumes bytes, drives RAM writes and status.
  modport master (
    input  rx_data, rx_valid,
    output ram_adr, ram_data, ram_we, start, busy, err_timeout, err_drop
  );

  // Environment side: supplies bytes, observes RAM writes and status.
  modport slave (
    output rx_data, rx_valid,
    input  ram_adr, ram_data, ram_we, start, busy, err_timeout, err_drop
  );

endinterface

// File: rtl/frame_loader.sv
// Hunts for the start byte, writes one frame into the receive RAM from address 0,
// announces it with a one-cycle start pulse, then ignores input for a guard window.
module frame_loader
  import frame_loader_pkg::*;
(
  input logic            clk,
  input logic            rst,
  frame_loader_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [15:0]      gap, gap_d;
  logic [15:0]      guard, guard_d;

  logic       we_q, we_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       tout_q, tout_d;
  logic       drop_q, drop_d;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state, counter and registered-output decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    gap_d   = gap;
    guard_d = guard;
    we_d    = 1'b0;
    adr_d   = adr_q;
    data_d  = data_q;
    start_d = 1'b0;
    tout_d  = 1'b0;
    drop_d  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == START_BYTE) begin
          we_d    = 1'b1;
          adr_d   = 8'h00;
          data_d  = bus.rx_data;
          idx_d   = IDX_W'(1);
          gap_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A byte wins over a timeout expiring in the same cycle.
        if (bus.rx_valid) begin
          we_d   = 1'b1;
          adr_d  = idx[7:0];
          data_d = bus.rx_data;
          gap_d  = '0;
          if (idx == LAST_IDX) state_d = DONE;
          else                 idx_d   = idx + 1'b1;
        end else if (gap == TIMEOUT) begin
          tout_d  = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap + 16'd1;
        end
      end
      DONE: begin
        // Final write was committed last cycle; announce the frame now.
        start_d = 1'b1;
        drop_d  = bus.rx_valid;
        guard_d = GUARD;
        idx_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        drop_d  = bus.rx_valid;
        guard_d = guard - 16'd1;
        if (guard == 16'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      gap     <= '0;
      guard   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      idx     <= idx_d;
      gap     <= gap_d;
      guard   <= guard_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ram_we      = we_q;
  assign bus.ram_adr     = adr_q;
  assign bus.ram_data    = data_q;
  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = tout_q;
  assign bus.err_drop    = drop_q;

endmodule
